serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
//  Mirror of the combinational full adder: a 1-bit full-subtractor cell plus a borrow flop,
//  sequenced by a start/busy/done FSM. Used in area-constrained datapaths of the ADDER
//  library where latency is acceptable. Flags cover unsigned borrow and signed overflow.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst_n     in   1      reset, asynchronous, active-low
//  start     in   1      request; sampled only in IDLE or DONE
//  A         in   WIDTH  minuend, captured on accepted start
//  B         in   WIDTH  subtrahend, captured on accepted start
//  Bin       in   1      borrow-in, captured on accepted start
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse: result valid
//  Diff      out  WIDTH  A - B - Bin mod 2^WIDTH; held until next accepted start
//  Bout      out  1      final borrow (1 when A < B + Bin unsigned)
//  overflow  out  1      signed overflow: A[MSB]!=B[MSB] && Diff[MSB]!=A[MSB]
// BEHAVIOUR
//  - Reset (rst_n=0, any time incl. mid-operation): state=IDLE, busy=0, done=0, Diff=0,
//    Bout=0, overflow=0, count=0, borrow flop=0; any operation in flight is abandoned.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE : start=1 -> load A/B shift regs, borrow<=Bin, count<=0, -> SHIFT. Else stay.
//    SHIFT: per cycle: d = a0^b0^brw; brw_next = (~a0&b0) | (~(a0^b0)&brw);
//           shift A,B right; shift d into Diff shadow at MSB; count++.
//           After WIDTH SHIFT cycles (count==WIDTH-1 processed) -> DONE.
//    DONE : done=1 for exactly this cycle; Diff/Bout/overflow updated from shadow.
//           start=1 here is accepted (back-to-back, same as IDLE); else -> IDLE.
//  - Latency: start sampled at edge 0 -> done high during cycle WIDTH+1 (edge WIDTH+1).
//    Throughput: one result per WIDTH+1 cycles.
//  - start while busy=1: ignored; operands/Bin on A/B/Bin ignored outside acceptance.
//  - Diff/Bout/overflow change only on entry to DONE; stable in IDLE and during SHIFT
//    (hold previous result). Shadow register is internal, never visible mid-operation.
//  - Arithmetic: exact mod 2^WIDTH; Bout is borrow out of MSB; no saturation.
//  - count is ceil(log2(WIDTH)) bits; no wrap beyond WIDTH-1.
//  - Outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package/header adder_defs: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2),
//    default WIDTH.
//  - Sub-module full_subtractor (1-bit comb: A, B, Bin -> D, Bout) instanced once in the
//    serial datapath; exhaustively checkable on its own like full_adder.
//  - Top: FSM + counter + two operand shift regs + Diff shadow + output regs (~150-250 lines).
// TESTING (WIDTH=8)
//  1. A=0x05,B=0x03,Bin=0, start 1 cycle -> busy 8 cycles, done at cycle 9: Diff=0x02,Bout=0,overflow=0.
//  2. A=0x00,B=0x01,Bin=0 -> Diff=0xFF, Bout=1, overflow=0.
//  3. A=0x80,B=0x01,Bin=0 -> Diff=0x7F, Bout=0, overflow=1; A=0x7F,B=0xFF -> Diff=0x80, Bout=1, overflow=1.
//  4. A=0x10,B=0x0F,Bin=1 -> Diff=0x00, Bout=0; then start held high in DONE -> next op accepted back-to-back.
//  5. Start A=0x05,B=0x03; at cycle 3 pulse start with A=0xFF,B=0x00 -> ignored; result 0x02.
//  6. Start A=0xAA,B=0x55; drop rst_n at SHIFT count 4 -> all outputs 0, no done; after release
//     A=0xAA,B=0x55 -> Diff=0x55, Bout=0, overflow=1.
//  Plus: random 1000 ops vs reference A-B-Bin model; full_subtractor exhaustive 8-vector check.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, Bout set when the bit borrows.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a single full_subtractor.
// Results appear on entry to DONE and are held until the next one completes.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shd_q, shd_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             busy_q, busy_d, done_q, done_d, bout_q, bout_d, ovf_q, ovf_d;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Bin (brw_q),
    .D   (fs_d),
    .Bout(fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    shd_d   = shd_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          shd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        shd_d = {fs_d, shd_q[WIDTH-1:1]};
        brw_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        // The last bit is folded straight into the visible result, so the shadow never leaks.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          diff_d  = {fs_d, shd_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      shd_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shd_q   <= shd_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Diff     = diff_q;
  assign Bout     = bout_q;
  assign overflow = ovf_q;

endmodule
